// File: rtl/bali_pkg.sv
// rtl/bali_pkg.sv - shared opcode constants, instruction length decode and fetch FSM states
package bali_pkg;

  localparam logic [7:0] BIPUSH       = 8'h10;
  localparam logic [7:0] SIPUSH       = 8'h11;
  localparam logic [7:0] LDC          = 8'h12;
  localparam logic [7:0] ILOAD        = 8'h15;
  localparam logic [7:0] ISTORE       = 8'h36;
  localparam logic [7:0] IINC         = 8'h84;
  localparam logic [7:0] IF_FIRST     = 8'h99;
  localparam logic [7:0] IF_LAST      = 8'ha7;
  localparam logic [7:0] INVOKESTATIC = 8'hb8;

  typedef enum logic [3:0] {
    IDLE,
    RD_OP,
    CAP_OP,
    RD_A1,
    CAP_A1,
    RD_A2,
    CAP_A2,
    RD_D,
    CAP_D
  } fetch_state_t;

  // Total instruction length in bytes (1..3), opcode included.
  function automatic logic [1:0] op_len(input logic [7:0] op);
    logic [1:0] len;
    len = 2'd1;
    if (op == BIPUSH || op == LDC || op == ILOAD || op == ISTORE)
      len = 2'd2;
    else if (op == SIPUSH || op == IINC || op == INVOKESTATIC ||
             (op >= IF_FIRST && op <= IF_LAST))
      len = 2'd3;
    return len;
  endfunction

endpackage

// File: rtl/bytecode_fetch.sv
// rtl/bytecode_fetch.sv - instruction/data fetch FSM owning the single program memory read port
module bytecode_fetch
  import bali_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] program_counter,
  input  logic                  data_req,
  input  logic [ADDR_WIDTH-1:0] dataindex,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [7:0]            mem_rdata,
  output logic [7:0]            op_code,
  output logic [7:0]            arg1,
  output logic [7:0]            arg2,
  output logic                  op_valid,
  output logic [31:0]           dataparams,
  output logic                  data_valid,
  output logic                  busy
);

  fetch_state_t state, state_nx;

  logic                  pend_i, pend_d;
  logic [ADDR_WIDTH-1:0] pc_lat, idx_lat, cur_addr;
  logic [1:0]            cnt;
  logic [7:0]            sh_op, sh_a1;
  logic [23:0]           sh_data;
  logic                  start_i, start_d, done_i, done_d, dispatch;

  assign mem_rd   = (state == RD_OP) || (state == RD_A1) ||
                    (state == RD_A2) || (state == RD_D);
  assign mem_addr = mem_rd ? cur_addr + ADDR_WIDTH'(cnt) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Completing states dispatch the next request directly, so back-to-back fetches have no bubble.
  always_comb begin
    state_nx = state;
    start_i  = 1'b0;
    start_d  = 1'b0;
    done_i   = 1'b0;
    done_d   = 1'b0;
    dispatch = 1'b0;
    unique case (state)
      IDLE:   dispatch = 1'b1;
      RD_OP:  state_nx = CAP_OP;
      CAP_OP: begin
        if (op_len(mem_rdata) == 2'd1) begin
          done_i   = 1'b1;
          dispatch = 1'b1;
        end else begin
          state_nx = RD_A1;
        end
      end
      RD_A1:  state_nx = CAP_A1;
      CAP_A1: begin
        if (op_len(sh_op) == 2'd2) begin
          done_i   = 1'b1;
          dispatch = 1'b1;
        end else begin
          state_nx = RD_A2;
        end
      end
      RD_A2:  state_nx = CAP_A2;
      CAP_A2: begin
        done_i   = 1'b1;
        dispatch = 1'b1;
      end
      RD_D:   state_nx = CAP_D;
      CAP_D: begin
        if (cnt == 2'd3) begin
          done_d   = 1'b1;
          dispatch = 1'b1;
        end else begin
          state_nx = RD_D;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (dispatch) begin
      if (pend_i || fetch_req) begin
        state_nx = RD_OP;
        start_i  = 1'b1;
      end else if (pend_d || data_req) begin
        state_nx = RD_D;
        start_d  = 1'b1;
      end else begin
        state_nx = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_i     <= 1'b0;
      pend_d     <= 1'b0;
      pc_lat     <= '0;
      idx_lat    <= '0;
      cur_addr   <= '0;
      cnt        <= 2'd0;
      sh_op      <= 8'h00;
      sh_a1      <= 8'h00;
      sh_data    <= 24'h0;
      op_code    <= 8'h00;
      arg1       <= 8'h00;
      arg2       <= 8'h00;
      op_valid   <= 1'b0;
      dataparams <= 32'h0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      op_valid   <= done_i;
      data_valid <= done_d;
      busy       <= (state_nx != IDLE);

      if (fetch_req) pc_lat  <= program_counter;
      if (data_req)  idx_lat <= dataindex;
      // A strobe on the serving edge only stays pending if it re-strobes an already pending request.
      pend_i <= start_i ? (pend_i & fetch_req) : (pend_i | fetch_req);
      pend_d <= start_d ? (pend_d & data_req)  : (pend_d | data_req);

      case (state)
        CAP_OP: begin
          sh_op <= mem_rdata;
          sh_a1 <= 8'h00;
          cnt   <= cnt + 2'd1;
          if (op_len(mem_rdata) == 2'd1) begin
            op_code <= mem_rdata;
            arg1    <= 8'h00;
            arg2    <= 8'h00;
          end
        end
        CAP_A1: begin
          sh_a1 <= mem_rdata;
          cnt   <= cnt + 2'd1;
          if (op_len(sh_op) == 2'd2) begin
            op_code <= sh_op;
            arg1    <= mem_rdata;
            arg2    <= 8'h00;
          end
        end
        CAP_A2: begin
          op_code <= sh_op;
          arg1    <= sh_a1;
          arg2    <= mem_rdata;
        end
        CAP_D: begin
          sh_data <= {sh_data[15:0], mem_rdata};
          cnt     <= cnt + 2'd1;
          if (cnt == 2'd3) dataparams <= {sh_data, mem_rdata};
        end
        default: ;
      endcase

      if (start_i) begin
        cur_addr <= pend_i ? pc_lat : program_counter;
        cnt      <= 2'd0;
      end else if (start_d) begin
        cur_addr <= pend_d ? idx_lat : dataindex;
        cnt      <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_bytecode_fetch.sv
// tb/tb_bytecode_fetch.sv - directed and randomized checks of bytecode_fetch against a byte-level model
module tb_bytecode_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req = 1'b0;
  logic [15:0] program_counter = '0;
  logic        data_req = 1'b0;
  logic [15:0] dataindex = '0;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata = '0;
  logic [7:0]  op_code, arg1, arg2;
  logic        op_valid;
  logic [31:0] dataparams;
  logic        data_valid;
  logic        busy;

  logic [7:0]  mem [0:65535];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc_cnt = 0;
  int          e0 = 0;

  bytecode_fetch #(.ADDR_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .program_counter(program_counter),
    .data_req(data_req), .dataindex(dataindex),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .op_code(op_code), .arg1(arg1), .arg2(arg2), .op_valid(op_valid),
    .dataparams(dataparams), .data_valid(data_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk)
    if (!rst && (op_valid || data_valid)) chk("valid_exclusive", {31'd0, op_valid & data_valid}, 32'd0);

  // Instruction length straight from the opcode table.
  function automatic int ref_len(input logic [7:0] op);
    if (op == 8'h10 || op == 8'h12 || op == 8'h15 || op == 8'h36) return 2;
    if (op == 8'h11 || op == 8'h84 || op == 8'hb8 || (op >= 8'h99 && op <= 8'ha7)) return 3;
    return 1;
  endfunction

  task automatic strobe(input bit do_i, input logic [15:0] pc, input bit do_d, input logic [15:0] idx);
    @(negedge clk);
    fetch_req = do_i; program_counter = pc;
    data_req = do_d; dataindex = idx;
    @(posedge clk); #1;
    e0 = cyc_cnt;
    fetch_req = 1'b0; data_req = 1'b0;
  endtask

  task automatic wait_valid(input bit is_data, output int lat);
    int n = 0;
    while (!(is_data ? data_valid : op_valid) && n < 64) begin
      @(posedge clk); #1; n++;
    end
    lat = cyc_cnt - e0;
  endtask

  task automatic expect_op(input string tag, input logic [15:0] pc, input int lat);
    int len;
    logic [15:0] a1, a2;
    logic [7:0] x1, x2;
    len = ref_len(mem[pc]);
    a1 = pc + 16'd1; a2 = pc + 16'd2;
    x1 = (len >= 2) ? mem[a1] : 8'h00;
    x2 = (len == 3) ? mem[a2] : 8'h00;
    chk({tag, "_op_lat"}, lat, 2 * len);
    chk({tag, "_op"}, op_code, mem[pc]);
    chk({tag, "_arg1"}, arg1, x1);
    chk({tag, "_arg2"}, arg2, x2);
  endtask

  function automatic logic [31:0] ref_word(input logic [15:0] idx);
    logic [15:0] a;
    logic [31:0] w;
    w = 0;
    for (int k = 0; k < 4; k++) begin
      a = idx + 16'(k);
      w = {w[23:0], mem[a]};
    end
    return w;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat2, seen, len, kind;
    logic [15:0] a;

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

    // Reset state
    @(posedge clk); #1;
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_op_code", op_code, 0);
    chk("rst_arg1", arg1, 0);
    chk("rst_arg2", arg2, 0);
    chk("rst_op_valid", op_valid, 0);
    chk("rst_dataparams", dataparams, 0);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk); rst = 1'b0;

    // bipush 5
    mem[0] = 8'h10; mem[1] = 8'h05;
    strobe(1, 16'h0000, 0, 0);
    chk("busy_after_accept", busy, 1);
    wait_valid(0, lat);
    expect_op("bipush", 16'h0000, lat);
    chk("bipush_arg1_val", arg1, 8'h05);
    @(posedge clk); #1;
    chk("op_valid_one_cycle", op_valid, 0);
    idle(3);

    // invokestatic then data one cycle later
    mem[4] = 8'hb8; mem[5] = 8'h00; mem[6] = 8'h02;
    mem[8] = 8'hde; mem[9] = 8'had; mem[10] = 8'hbe; mem[11] = 8'hef;
    strobe(1, 16'h0004, 0, 0);
    @(negedge clk); data_req = 1'b1; dataindex = 16'h0008;
    @(posedge clk); #1; data_req = 1'b0;
    wait_valid(0, lat);
    chk("invs_lat", lat, 6);
    chk("invs_op", op_code, 8'hb8);
    chk("invs_arg1", arg1, 8'h00);
    chk("invs_arg2", arg2, 8'h02);
    wait_valid(1, lat);
    chk("invs_data_lat", lat, 14);
    chk("invs_data", dataparams, 32'hdeadbeef);
    @(posedge clk); #1;
    chk("data_valid_one_cycle", data_valid, 0);
    idle(3);

    // Simultaneous requests: instruction first
    mem[0] = 8'h60;
    strobe(1, 16'h0000, 1, 16'h0008);
    wait_valid(0, lat);
    chk("simul_op_lat", lat, 2);
    chk("simul_op", op_code, 8'h60);
    chk("simul_arg1", arg1, 8'h00);
    @(posedge clk); #1;
    wait_valid(1, lat);
    chk("simul_data_lat", lat, 10);
    chk("simul_data", dataparams, 32'hdeadbeef);
    idle(3);

    // Data address wrap
    mem[16'hfffe] = 8'h01; mem[16'hffff] = 8'h02; mem[0] = 8'h03; mem[1] = 8'h04;
    strobe(0, 0, 1, 16'hfffe);
    wait_valid(1, lat);
    chk("wrap_lat", lat, 8);
    chk("wrap_data", dataparams, 32'h01020304);
    idle(3);

    // Reset during CAP_A1 of a 3-byte fetch
    strobe(1, 16'h0004, 0, 0);
    idle(3);
    rst = 1'b1; #1;
    chk("midrst_op_code", op_code, 0);
    chk("midrst_arg1", arg1, 0);
    chk("midrst_dataparams", dataparams, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_mem_rd", mem_rd, 0);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (op_valid) seen++;
    end
    chk("midrst_no_valid", seen, 0);
    strobe(1, 16'h0004, 0, 0);
    wait_valid(0, lat);
    expect_op("postrst", 16'h0004, lat);
    idle(3);

    // Two fetches while busy: no bubble
    mem[0] = 8'h10; mem[1] = 8'h05; mem[2] = 8'h60;
    strobe(1, 16'h0000, 0, 0);
    @(negedge clk); fetch_req = 1'b1; program_counter = 16'h0002;
    @(posedge clk); #1; fetch_req = 1'b0;
    wait_valid(0, lat);
    expect_op("b2b_first", 16'h0000, lat);
    chk("b2b_mem_rd", mem_rd, 1);
    chk("b2b_mem_addr", mem_addr, 16'h0002);
    @(posedge clk); #1;
    chk("b2b_gap", op_valid, 0);
    wait_valid(0, lat);
    chk("b2b_second_lat", lat, 6);
    chk("b2b_second_op", op_code, 8'h60);
    chk("b2b_second_arg1", arg1, 8'h00);
    idle(3);

    // Randomized fetches against the model
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 2);
      a = 16'($urandom);
      if (kind == 0) begin
        strobe(1, a, 0, 0);
        wait_valid(0, lat);
        expect_op("rand_i", a, lat);
      end else if (kind == 1) begin
        strobe(0, 0, 1, a);
        wait_valid(1, lat);
        chk("rand_d_lat", lat, 8);
        chk("rand_d", dataparams, ref_word(a));
      end else begin
        logic [15:0] b;
        b = 16'($urandom);
        strobe(1, a, 1, b);
        len = ref_len(mem[a]);
        wait_valid(0, lat);
        expect_op("rand_both", a, lat);
        @(posedge clk); #1;
        wait_valid(1, lat2);
        chk("rand_both_d_lat", lat2, 2 * len + 8);
        chk("rand_both_d", dataparams, ref_word(b));
      end
      idle($urandom_range(1, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
